// File: rtl/reg_bus_arbiter_if.sv
// Request/grant/done bundle between the protocol engines, the arbiter and the
// register I/O sequencer. The arbiter takes the slave side.
interface reg_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OFFSET_W    = 8,
    parameter int DATA_W      = 16,
    parameter int MASTER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
    logic [NUM_MASTERS-1:0]          req;
    logic [NUM_MASTERS-1:0]          lock;
    logic [NUM_MASTERS*OFFSET_W-1:0] req_offset;
    logic [NUM_MASTERS-1:0]          req_length;
    logic [NUM_MASTERS-1:0]          req_wr;
    logic [NUM_MASTERS*DATA_W-1:0]   req_wdata;
    logic [NUM_MASTERS-1:0]          grant;
    logic [NUM_MASTERS-1:0]          done;
    logic                            err;
    logic [DATA_W-1:0]               rdata;
    logic [MASTER_W-1:0]             cur_master;
    logic                            timeout_err;
    logic [OFFSET_W-1:0]             offset;
    logic                            length;
    logic                            WR;
    logic [DATA_W-1:0]               writeData;
    logic                            NewCommand;
    logic [DATA_W-1:0]               readData;
    logic                            reg_done;

    modport slave (
        input  req, lock, req_offset, req_length, req_wr, req_wdata, readData, reg_done,
        output grant, done, err, rdata, cur_master, timeout_err,
               offset, length, WR, writeData, NewCommand
    );

    modport master (
        output req, lock, req_offset, req_length, req_wr, req_wdata, readData, reg_done,
        input  grant, done, err, rdata, cur_master, timeout_err,
               offset, length, WR, writeData, NewCommand
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Shares the single register port among NUM_MASTERS requesters with fixed or
// round-robin selection, per-master burst lock and a transaction watchdog.
module reg_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int OFFSET_W    = 8,
    parameter int DATA_W      = 16,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 1023,
    parameter int MASTER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic              clk40m,
    input  logic              reset,
    reg_bus_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant, r_done;
    logic                   r_err, r_timeout_err, r_new_cmd, r_length, r_wr;
    logic [DATA_W-1:0]      r_rdata, r_wdata;
    logic [OFFSET_W-1:0]    r_offset;
    logic [MASTER_W-1:0]    r_cur, r_rr_ptr;
    logic [CNT_W-1:0]       r_cnt;

    logic [MASTER_W-1:0]    w_win, w_src, w_next_ptr;
    logic                   w_any;
    int                     w_idx;
    logic [OFFSET_W-1:0]    w_off;
    logic [DATA_W-1:0]      w_wd;
    logic                   w_len, w_wr, w_relock;

    // Scan from the pointer (always 0 in fixed mode), first asserted request wins.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = ((RR_MODE != 0) ? int'(r_rr_ptr) : 0) + k;
            if (w_idx >= NUM_MASTERS) w_idx = w_idx - NUM_MASTERS;
            if (!w_any && bus.req[w_idx]) begin
                w_any = 1'b1;
                w_win = MASTER_W'(w_idx);
            end
        end
    end

    // Fields come from the new winner in IDLE, from the owner on a locked re-issue.
    assign w_src      = (r_state == IDLE) ? w_win : r_cur;
    assign w_off      = bus.req_offset[int'(w_src)*OFFSET_W +: OFFSET_W];
    assign w_wd       = bus.req_wdata[int'(w_src)*DATA_W +: DATA_W];
    assign w_len      = bus.req_length[w_src];
    assign w_wr       = bus.req_wr[w_src];
    assign w_relock   = bus.lock[r_cur] && bus.req[r_cur];
    assign w_next_ptr = (int'(r_cur) == NUM_MASTERS - 1) ? '0 : r_cur + 1'b1;

    always_ff @(posedge clk40m) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_done        <= '0;
            r_err         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_new_cmd     <= 1'b0;
            r_offset      <= '0;
            r_length      <= 1'b0;
            r_wr          <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_cur         <= '0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant  <= NUM_MASTERS'(1) << w_win;
                    r_cur    <= w_win;
                    r_offset <= w_off;
                    r_length <= w_len;
                    r_wr     <= w_wr;
                    r_wdata  <= w_wd;
                    r_state  <= ISSUE;
                end
                ISSUE: begin
                    r_new_cmd <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    r_new_cmd <= 1'b0;
                    if (bus.reg_done) begin
                        r_rdata <= bus.readData;
                        r_done  <= r_grant;
                        if (w_relock) begin
                            // Burst continues: start the next command alongside done.
                            r_offset  <= w_off;
                            r_length  <= w_len;
                            r_wr      <= w_wr;
                            r_wdata   <= w_wd;
                            r_new_cmd <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_grant  <= '0;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= IDLE;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_rdata       <= '0;
                        r_done        <= r_grant;
                        r_err         <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.rdata       = r_rdata;
    assign bus.cur_master  = r_cur;
    assign bus.timeout_err = r_timeout_err;
    assign bus.offset      = r_offset;
    assign bus.length      = r_length;
    assign bus.WR          = r_wr;
    assign bus.writeData   = r_wdata;
    assign bus.NewCommand  = r_new_cmd;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench: fixed-priority/timeout/reset on u0, round robin on u1,
// two-master wide-bus slicing on u2.
module tb_reg_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.NUM_MASTERS(4), .OFFSET_W(8),  .DATA_W(16)) if0 ();
    reg_bus_arbiter_if #(.NUM_MASTERS(4), .OFFSET_W(8),  .DATA_W(16)) if1 ();
    reg_bus_arbiter_if #(.NUM_MASTERS(2), .OFFSET_W(10), .DATA_W(32)) if2 ();

    reg_bus_arbiter #(.NUM_MASTERS(4), .OFFSET_W(8), .DATA_W(16), .RR_MODE(0), .TIMEOUT(15))
        u0 (.clk40m(clk), .reset(reset), .bus(if0));
    reg_bus_arbiter #(.NUM_MASTERS(4), .OFFSET_W(8), .DATA_W(16), .RR_MODE(1), .TIMEOUT(1023))
        u1 (.clk40m(clk), .reset(reset), .bus(if1));
    reg_bus_arbiter #(.NUM_MASTERS(2), .OFFSET_W(10), .DATA_W(32), .RR_MODE(0), .TIMEOUT(31))
        u2 (.clk40m(clk), .reset(reset), .bus(if2));

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        int          exp_idx;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        int n;
        if0.req = '0; if0.lock = '0; if0.reg_done = 1'b0; if0.readData = '0;
        if1.req = '0; if1.lock = '0; if1.reg_done = 1'b0; if1.readData = '0;
        if2.req = '0; if2.lock = '0; if2.reg_done = 1'b0; if2.readData = '0;
        for (int i = 0; i < 4; i++) begin
            if0.req_offset[i*8 +: 8]  = 8'(8'h10 + i);
            if0.req_wdata[i*16 +: 16] = 16'(16'hA000 + i);
            if0.req_length[i]         = i[0];
            if0.req_wr[i]             = i[1];
            if1.req_offset[i*8 +: 8]  = 8'(8'h10 + i);
            if1.req_wdata[i*16 +: 16] = 16'(16'hA000 + i);
            if1.req_length[i]         = i[0];
            if1.req_wr[i]             = i[1];
        end
        if2.req_offset = {10'h2AB, 10'h155};
        if2.req_wdata  = {32'hDEADBEEF, 32'h0BADF00D};
        if2.req_length = 2'b10;
        if2.req_wr     = 2'b01;

        vecs[0] = '{4'b1000, 4'b1000, 3, 16'h1234};
        vecs[1] = '{4'b1111, 4'b0001, 0, 16'h00FF};
        vecs[2] = '{4'b1100, 4'b0100, 2, 16'hFFFF};
        vecs[3] = '{4'b1010, 4'b0010, 1, 16'h5A5A};
        vecs[4] = '{4'b0101, 4'b0001, 0, 16'hC3C3};

        tick(); tick();
        chk("rst_grant", 32'(if0.grant), 0);
        chk("rst_newcmd", 32'(if0.NewCommand), 0);
        chk("rst_cur", 32'(if0.cur_master), 0);
        chk("rst_toerr", 32'(if0.timeout_err), 0);
        reset = 1'b0;
        tick();

        // Basic handshake and one-cycle-late rearbitration.
        if0.req = 4'b0110;
        tick();
        chk("h_grant", 32'(if0.grant), 32'h2);
        chk("h_nc_early", 32'(if0.NewCommand), 0);
        tick();
        chk("h_nc", 32'(if0.NewCommand), 1);
        tick();
        chk("h_nc_drop", 32'(if0.NewCommand), 0);
        if0.reg_done = 1'b1; if0.readData = 16'h8872;
        tick();
        chk("h_done", 32'(if0.done), 32'h2);
        chk("h_rdata", 32'(if0.rdata), 32'h8872);
        chk("h_err", 32'(if0.err), 0);
        chk("h_grant_clr", 32'(if0.grant), 0);
        if0.reg_done = 1'b0; if0.req = 4'b0100;
        tick();
        chk("h_done_pulse", 32'(if0.done), 0);
        chk("h_grant2", 32'(if0.grant), 32'h4);
        chk("h_nc2_early", 32'(if0.NewCommand), 0);
        tick();
        chk("h_nc2", 32'(if0.NewCommand), 1);
        if0.reg_done = 1'b1;
        tick();
        chk("h_done2", 32'(if0.done), 32'h4);
        if0.reg_done = 1'b0; if0.req = '0;
        tick();

        // Fixed-priority table.
        for (int v = 0; v < 5; v++) begin
            if0.req = vecs[v].req;
            tick();
            chk($sformatf("v%0d_grant", v), 32'(if0.grant), 32'(vecs[v].exp_grant));
            chk($sformatf("v%0d_cur", v), 32'(if0.cur_master), 32'(vecs[v].exp_idx));
            chk($sformatf("v%0d_off", v), 32'(if0.offset), 32'(8'h10 + vecs[v].exp_idx));
            chk($sformatf("v%0d_wd", v), 32'(if0.writeData), 32'(16'hA000 + vecs[v].exp_idx));
            chk($sformatf("v%0d_len", v), 32'(if0.length), 32'(vecs[v].exp_idx % 2));
            chk($sformatf("v%0d_wr", v), 32'(if0.WR), 32'(vecs[v].exp_idx / 2));
            tick();
            chk($sformatf("v%0d_nc", v), 32'(if0.NewCommand), 1);
            if0.reg_done = 1'b1; if0.readData = vecs[v].rd;
            tick();
            chk($sformatf("v%0d_done", v), 32'(if0.done), 32'(vecs[v].exp_grant));
            chk($sformatf("v%0d_rdata", v), 32'(if0.rdata), 32'(vecs[v].rd));
            if0.reg_done = 1'b0; if0.req = '0;
            tick();
        end

        // reg_done while idle must not produce a completion.
        if0.reg_done = 1'b1;
        tick();
        chk("idle_done", 32'(if0.done), 0);
        chk("idle_grant", 32'(if0.grant), 0);
        if0.reg_done = 1'b0;
        tick();

        // Three-command locked burst by master 1 while master 0 waits.
        if0.req = 4'b0010; if0.lock = 4'b0010;
        tick();
        chk("lk_grant", 32'(if0.grant), 32'h2);
        if0.req = 4'b0011;
        tick();
        chk("lk_nc0", 32'(if0.NewCommand), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) if0.lock = 4'b0000;
            if0.reg_done = 1'b1; if0.readData = 16'(16'h1000 + c);
            tick();
            chk($sformatf("lk_done%0d", c), 32'(if0.done), 32'h2);
            chk($sformatf("lk_rdata%0d", c), 32'(if0.rdata), 32'(16'h1000 + c));
            if (c < 2) begin
                chk($sformatf("lk_nc_with_done%0d", c), 32'(if0.NewCommand), 1);
                chk($sformatf("lk_hold%0d", c), 32'(if0.grant), 32'h2);
            end else begin
                chk("lk_release_nc", 32'(if0.NewCommand), 0);
                chk("lk_release_grant", 32'(if0.grant), 0);
            end
            if0.reg_done = 1'b0;
        end
        if0.req = 4'b0001;
        tick();
        chk("lk_next_grant", 32'(if0.grant), 32'h1);
        chk("lk_next_cur", 32'(if0.cur_master), 0);
        tick();
        if0.reg_done = 1'b1;
        tick();
        chk("lk_next_done", 32'(if0.done), 32'h1);
        if0.reg_done = 1'b0; if0.req = '0;
        tick();

        // Watchdog with TIMEOUT = 15.
        if0.req = 4'b0100;
        tick();
        tick();
        chk("to_nc", 32'(if0.NewCommand), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (if0.done == 4'b0000 && n < 40);
        chk("to_cycles", 32'(n), 16);
        chk("to_done", 32'(if0.done), 32'h4);
        chk("to_err", 32'(if0.err), 1);
        chk("to_rdata", 32'(if0.rdata), 0);
        chk("to_sticky", 32'(if0.timeout_err), 1);
        chk("to_grant", 32'(if0.grant), 0);
        if0.req = '0;
        tick();
        chk("to_err_pulse", 32'(if0.err), 0);
        if0.req = 4'b1000;
        tick(); tick();
        if0.reg_done = 1'b1; if0.readData = 16'h0F0F;
        tick();
        chk("to_after_done", 32'(if0.done), 32'h8);
        chk("to_after_err", 32'(if0.err), 0);
        chk("to_after_sticky", 32'(if0.timeout_err), 1);
        if0.reg_done = 1'b0; if0.req = '0;
        tick();

        // Round robin with all four requesting.
        if1.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rr_grant%0d", c), 32'(if1.grant), 32'(1 << (c % 4)));
            tick();
            chk($sformatf("rr_nc%0d", c), 32'(if1.NewCommand), 1);
            if1.reg_done = 1'b1; if1.readData = 16'(c);
            tick();
            chk($sformatf("rr_done%0d", c), 32'(if1.done), 32'(1 << (c % 4)));
            if1.reg_done = 1'b0;
        end
        if1.req = '0;
        tick();

        // Two masters, 10-bit offsets, 32-bit data.
        if2.req = 2'b10;
        tick();
        chk("w_grant1", 32'(if2.grant), 32'h2);
        chk("w_cur1", 32'(if2.cur_master), 1);
        chk("w_off1", 32'(if2.offset), 32'h2AB);
        chk("w_wd1", 32'(if2.writeData), 32'hDEADBEEF);
        chk("w_len1", 32'(if2.length), 1);
        chk("w_wr1", 32'(if2.WR), 0);
        tick();
        if2.reg_done = 1'b1; if2.readData = 32'h12345678;
        tick();
        chk("w_done1", 32'(if2.done), 32'h2);
        chk("w_rdata1", 32'(if2.rdata), 32'h12345678);
        if2.reg_done = 1'b0; if2.req = 2'b11;
        tick();
        chk("w_grant0", 32'(if2.grant), 32'h1);
        chk("w_off0", 32'(if2.offset), 32'h155);
        chk("w_wd0", 32'(if2.writeData), 32'h0BADF00D);
        chk("w_wr0", 32'(if2.WR), 1);
        tick();
        if2.reg_done = 1'b1; if2.readData = 32'h87654321;
        tick();
        chk("w_done0", 32'(if2.done), 32'h1);
        chk("w_rdata0", 32'(if2.rdata), 32'h87654321);
        if2.reg_done = 1'b0; if2.req = '0;
        tick();

        // Reset in WAIT clears everything without a completion.
        if0.req = 4'b0010;
        tick(); tick(); tick();
        reset = 1'b1; if0.req = '0;
        tick();
        chk("rw_grant", 32'(if0.grant), 0);
        chk("rw_done", 32'(if0.done), 0);
        chk("rw_err", 32'(if0.err), 0);
        chk("rw_nc", 32'(if0.NewCommand), 0);
        chk("rw_off", 32'(if0.offset), 0);
        chk("rw_len", 32'(if0.length), 0);
        chk("rw_wr", 32'(if0.WR), 0);
        chk("rw_wd", 32'(if0.writeData), 0);
        chk("rw_rdata", 32'(if0.rdata), 0);
        chk("rw_cur", 32'(if0.cur_master), 0);
        chk("rw_toerr", 32'(if0.timeout_err), 0);
        reset = 1'b0;
        if0.reg_done = 1'b1;
        tick();
        chk("rw_no_done", 32'(if0.done), 0);
        if0.reg_done = 1'b0; if0.req = 4'b0100;
        tick();
        chk("rw_fresh_grant", 32'(if0.grant), 32'h4);
        chk("rw_fresh_off", 32'(if0.offset), 32'h12);
        tick();
        chk("rw_fresh_nc", 32'(if0.NewCommand), 1);
        if0.reg_done = 1'b1; if0.readData = 16'hBEEF;
        tick();
        chk("rw_fresh_done", 32'(if0.done), 32'h4);
        chk("rw_fresh_rdata", 32'(if0.rdata), 32'hBEEF);
        if0.reg_done = 1'b0; if0.req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
